cla_seq_adder_ctrl: RTL
=======================

// Module: cla_seq_adder_ctrl
// PURPOSE
//  Sequencer that time-multiplexes one 4-bit carry-lookahead slice (mfa + cla_4 via if_mfa_cla)
//  to add two OP_WIDTH-bit operands, 4 bits per cycle, LSB slice first.
//  Inter-slice carry is held in a register, so area stays at one slice regardless of width.
//  Sits between an operand producer and a result consumer; valid/ready handshake on both sides.
// PARAMETERS
//  OP_WIDTH  32  operand/result width; multiple of 4 and >= 4, else $error at elaboration
//  NSLICE    OP_WIDTH/4 (localparam)  number of slice cycles per operation
// PORTS
//  clk        in   1         single clock, all state on rising edge
//  rst        in   1         synchronous, active-high reset
//  in_valid   in   1         operand request valid
//  in_ready   out  1         controller can accept operands
//  a          in   OP_WIDTH  operand A
//  b          in   OP_WIDTH  operand B
//  cin        in   1         carry-in to slice 0
//  out_valid  out  1         result valid
//  out_ready  in   1         consumer accepts result
//  sum        out  OP_WIDTH  a + b + cin, low OP_WIDTH bits
//  cout       out  1         carry out of MSB slice
//  busy       out  1         state != IDLE
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE; in_ready=1, out_valid=0, busy=0, sum=0, cout=0;
//    slice index, carry and operand registers cleared. Reset mid-operation aborts it silently.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&&in_ready latch a,b into shift registers, carry<=cin,
//    idx<=0, sum reg<=0, go RUN. No acceptance in RUN/DONE (in_ready=0).
//  - RUN: slice in1=a_sh[3:0], in2=b_sh[3:0], czero=carry. Each cycle:
//    sum[4*idx+:4]<=slice sum; carry<=ggn|(gpr&carry); a_sh,b_sh>>=4; idx++.
//    When idx==NSLICE-1 that edge writes last slice, cout<=new carry, go DONE.
//  - Latency: out_valid rises exactly NSLICE cycles after the accept edge (8 for OP_WIDTH=32).
//  - DONE: out_valid=1; sum/cout stable until out_valid&&out_ready, then IDLE next cycle.
//    Min issue interval NSLICE+2 cycles. in_valid held in RUN/DONE is ignored, not lost.
//  - Slice is purely combinational; its sum/carry sampled only in RUN. In IDLE/DONE its
//    inputs are driven 0 (czero=0) to avoid toggling.
//  - Width rule: result modulo 2^OP_WIDTH; cout is bit OP_WIDTH of a+b+cin.
//  - NSLICE=1: RUN lasts one cycle; idx logic must not over/underflow ($clog2 guarded to >=1 bit).
//  - out_ready in IDLE/RUN ignored; in_valid/out_ready may both be high in DONE: only result
//    retires, new operand accepted earliest next (IDLE) cycle.
// CONFIGURATION
//  CLA_SEQ_OVF_EN defined: extra output port `ovf  out  1` = two's-complement signed overflow,
//    computed at final slice as carry into MSB xor carry out of MSB (internal carry into bit
//    OP_WIDTH-1 recomputed from slice inputs); reset 0, valid/held with sum.
//  Not defined: port absent, no overflow logic; all other behaviour identical.
// TESTING
//  1. 0xFFFFFFFF + 0x00000001, cin=0 -> after 8 cycles sum=0x00000000, cout=1.
//  2. 0x12345678 + 0x9ABCDEF0, cin=0 -> sum=0xACF13568, cout=0; in_ready=0 throughout RUN/DONE.
//  3. 0 + 0, cin=1 -> sum=0x00000001, cout=0 (carry-in reaches slice 0 only).
//  4. Backpressure: out_ready=0 for 5 cycles in DONE -> sum/cout/out_valid stable, in_valid held
//     high not accepted until cycle after retire.
//  5. rst=1 on 3rd RUN cycle -> next cycle state IDLE, in_ready=1, out_valid=0, sum=0; fresh op ok.
//  6. CLA_SEQ_OVF_EN: 0x7FFFFFFF + 1 -> ovf=1, cout=0; 0xFFFFFFFF + 1 -> ovf=0, cout=1.

Source files
------------

// File: rtl/cla_seq_adder_ctrl.sv
// cla_seq_adder_ctrl: adds two OP_WIDTH-bit operands by stepping one 4-bit
// carry-lookahead slice across them, LSB nibble first, one nibble per cycle.
// The carry between nibbles is held in a register, so only one slice is built
// whatever the operand width.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   in_valid / in_ready   operand handshake (accepted only in IDLE)
//   a, b, cin             operands and carry-in to the first slice
//   out_valid / out_ready result handshake (result held until retired)
//   sum, cout             a + b + cin modulo 2^OP_WIDTH, and bit OP_WIDTH
//   busy                  high whenever the FSM is not IDLE
//   ovf                   signed overflow, present only with CLA_SEQ_OVF_EN
//
// Build option: define CLA_SEQ_OVF_EN to add the ovf output.

// One 4-bit slice: per-bit generate/propagate cells plus lookahead carries.
module cla_slice4 (
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic       czero,
  output logic [3:0] s,
  output logic       ggn,   // group generate
  output logic       gpr,   // group propagate
  output logic       c3     // carry into bit 3
);
  logic [3:0] g, p, c;

  for (genvar i = 0; i < 4; i++) begin : g_mfa
    assign g[i] = in1[i] & in2[i];
    assign p[i] = in1[i] ^ in2[i];
    assign s[i] = p[i] ^ c[i];
  end

  assign c[0] = czero;
  assign c[1] = g[0] | (p[0] & czero);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & czero);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & czero);
  assign c3   = c[3];
  assign ggn  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign gpr  = &p;
endmodule

module cla_seq_adder_ctrl #(
  parameter int OP_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_WIDTH-1:0] a,
  input  logic [OP_WIDTH-1:0] b,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OP_WIDTH-1:0] sum,
  output logic                cout,
  output logic                busy
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic                ovf
`endif
);
  localparam int NSLICE = OP_WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

  if ((OP_WIDTH % 4) != 0 || OP_WIDTH < 4) begin : g_bad_width
    $error("cla_seq_adder_ctrl: OP_WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [OP_WIDTH-1:0] a_sh, b_sh, sum_r;
  logic [IDXW-1:0]     idx;
  logic                carry, cout_r;
  logic [3:0]          sl_in1, sl_in2, sl_s;
  logic                sl_cz, sl_ggn, sl_gpr, sl_c3, carry_nxt;
  logic                last;

  // Slice inputs are held at zero outside RUN so the slice does not toggle.
  assign sl_in1    = (state == RUN) ? a_sh[3:0] : 4'd0;
  assign sl_in2    = (state == RUN) ? b_sh[3:0] : 4'd0;
  assign sl_cz     = (state == RUN) ? carry     : 1'b0;
  assign carry_nxt = sl_ggn | (sl_gpr & carry);
  assign last      = (idx == LAST);

  cla_slice4 u_slice (
    .in1   (sl_in1),
    .in2   (sl_in2),
    .czero (sl_cz),
    .s     (sl_s),
    .ggn   (sl_ggn),
    .gpr   (sl_gpr),
    .c3    (sl_c3)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = RUN;
      end
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh  <= a;
          b_sh  <= b;
          carry <= cin;
          idx   <= '0;
          sum_r <= '0;
        end
        RUN: begin
          sum_r[4*idx +: 4] <= sl_s;
          carry <= carry_nxt;
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          // Wrap instead of incrementing past the last slice (matters when NSLICE is not a power of 2).
          idx   <= last ? '0 : idx + 1'b1;
          if (last) cout_r <= carry_nxt;
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;

`ifdef CLA_SEQ_OVF_EN
  // Signed overflow: carry into the MSB (carry into bit 3 of the last slice) xor carry out.
  logic ovf_r;
  always_ff @(posedge clk) begin
    if (rst)                     ovf_r <= 1'b0;
    else if (state == RUN && last) ovf_r <= sl_c3 ^ carry_nxt;
  end
  assign ovf = ovf_r;
`else
  logic unused_c3;
  assign unused_c3 = sl_c3;
`endif
endmodule
